// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Round-robin or fixed priority, with lock ownership and tagged read return.
module ram_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        ram_wr_sig,
    output logic [31:0] ram_wr_data,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   grant0, grant1;
    logic   rd_accept;
    logic   [RD_LATENCY-1:0] tag_vld;
    logic   [RD_LATENCY-1:0] tag_own;
    logic   [31:0] rdata0_q, rdata1_q;

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_nxt = state;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        // last_grant == 1 means port 0 is owed the tie
                        if ((FIXED_PRIO != 0) || last_grant)
                            grant0 = 1'b1;
                        else
                            grant1 = 1'b1;
                    end else begin
                        grant0 = m0_req;
                        grant1 = m1_req;
                    end
                    if (grant0 && m0_lock)
                        state_nxt = OWN0;
                    else if (grant1 && m1_lock)
                        state_nxt = OWN1;
                end
                OWN0: begin
                    grant0 = m0_req;
                    if (!m0_lock)
                        state_nxt = IDLE;
                end
                OWN1: begin
                    grant1 = m1_req;
                    if (!m1_lock)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign m0_ready  = grant0;
    assign m1_ready  = grant1;
    assign rd_accept = (grant0 && !m0_we) || (grant1 && !m1_we);

    always_comb begin
        ram_wr_sig  = 1'b0;
        ram_wr_data = 32'h0;
        ram_addr    = 32'h0;
        if (grant0) begin
            ram_wr_sig  = m0_we;
            ram_wr_data = m0_wdata;
            ram_addr    = m0_addr;
        end else if (grant1) begin
            ram_wr_sig  = m1_we;
            ram_wr_data = m1_wdata;
            ram_addr    = m1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tag_vld    <= '0;
            tag_own    <= '0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1)
                last_grant <= grant1;
            tag_vld[0] <= rd_accept;
            tag_own[0] <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
            if (m0_rvalid)
                rdata0_q <= ram_rd_data;
            if (m1_rvalid)
                rdata1_q <= ram_rd_data;
        end
    end

    assign m0_rvalid = !reset && tag_vld[RD_LATENCY-1] && !tag_own[RD_LATENCY-1];
    assign m1_rvalid = !reset && tag_vld[RD_LATENCY-1] && tag_own[RD_LATENCY-1];
    assign m0_rdata  = m0_rvalid ? ram_rd_data : rdata0_q;
    assign m1_rdata  = m1_rvalid ? ram_rd_data : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: three instances share stimulus
// (lat 1 round-robin with RAM model, lat 3 round-robin, lat 1 fixed priority).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;

    logic        a_m0_ready, a_m0_rvalid, a_m1_ready, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_wr;
    logic [31:0] a_wdata, a_addr, a_rd;

    logic        b_m0_ready, b_m0_rvalid, b_m1_ready, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_wr;
    logic [31:0] b_wdata, b_addr;

    logic        c_m0_ready, c_m0_rvalid, c_m1_ready, c_m1_rvalid;
    logic [31:0] c_m0_rdata, c_m1_rdata;
    logic        c_wr;
    logic [31:0] c_wdata, c_addr;

    logic [31:0] mem [64];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // RAM model with one cycle read latency for instance a
    always @(posedge clk) begin
        if (a_wr)
            mem[a_addr[7:2]] <= a_wdata;
        a_rd <= mem[a_addr[7:2]];
    end

    ram_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(a_m0_ready), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(a_m1_ready), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .ram_wr_sig(a_wr), .ram_wr_data(a_wdata), .ram_addr(a_addr),
        .ram_rd_data(a_rd)
    );

    ram_arbiter #(.RD_LATENCY(3), .FIXED_PRIO(0)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(b_m0_ready), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(b_m1_ready), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_wr_sig(b_wr), .ram_wr_data(b_wdata), .ram_addr(b_addr),
        .ram_rd_data(32'h0)
    );

    ram_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1)) dut_c (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(c_m0_ready), .m0_rvalid(c_m0_rvalid), .m0_rdata(c_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(c_m1_ready), .m1_rvalid(c_m1_rvalid), .m1_rdata(c_m1_rdata),
        .ram_wr_sig(c_wr), .ram_wr_data(c_wdata), .ram_addr(c_addr),
        .ram_rd_data(32'h0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h0;
        drop();
        reset = 1;
        tick();
        tick();

        // outputs while reset is high, even with both requesting
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h55;
        m1_req = 1;
        #1;
        check("rst_m0_ready", a_m0_ready, 0);
        check("rst_m1_ready", a_m1_ready, 0);
        check("rst_ram_wr", a_wr, 0);
        check("rst_ram_addr", a_addr, 0);
        check("rst_ram_wdata", a_wdata, 0);
        check("rst_m0_rdata", a_m0_rdata, 0);
        check("rst_m1_rdata", a_m1_rdata, 0);
        drop();
        reset = 0;
        tick();

        // solo write then read through port 0
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        #1;
        check("wr_m0_ready", a_m0_ready, 1);
        check("wr_ram_wr", a_wr, 1);
        check("wr_ram_addr", a_addr, 32'h10);
        check("wr_ram_wdata", a_wdata, 32'hDEADBEEF);
        tick();
        check("wr_no_rvalid", a_m0_rvalid, 0);
        m0_we = 0;
        #1;
        check("rd_m0_ready", a_m0_ready, 1);
        check("rd_ram_wr", a_wr, 0);
        tick();
        drop();
        #1;
        check("rd_m0_rvalid", a_m0_rvalid, 1);
        check("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("rd_m1_rvalid", a_m1_rvalid, 0);
        tick();
        check("rd_m0_rvalid_off", a_m0_rvalid, 0);
        check("rd_m0_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

        m1_req = 1; m1_we = 1; m1_addr = 32'h14; m1_wdata = 32'hCAFEF00D;
        #1;
        check("wr1_m1_ready", a_m1_ready, 1);
        tick();
        drop();

        // round-robin from reset with both ports reading continuously
        pulse_reset();
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_m0_ready", a_m0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_m1_ready", a_m1_ready, (i % 2 == 1) ? 1 : 0);
            check("rr_b_m0_ready", b_m0_ready, (i % 2 == 0) ? 1 : 0);
            check("fp_m0_ready", c_m0_ready, 1);
            check("fp_m1_ready", c_m1_ready, 0);
            if (i > 0) begin
                check("rr_m0_rvalid", a_m0_rvalid, (i % 2 == 1) ? 1 : 0);
                check("rr_m1_rvalid", a_m1_rvalid, (i % 2 == 0) ? 1 : 0);
                check("rr_rdata", (i % 2 == 1) ? a_m0_rdata : a_m1_rdata,
                      (i % 2 == 1) ? 32'hDEADBEEF : 32'hCAFEF00D);
            end
            tick();
        end
        drop();
        #1;
        check("rr_last_m1_rvalid", a_m1_rvalid, 1);
        check("rr_last_m1_rdata", a_m1_rdata, 32'hCAFEF00D);
        check("rr_last_m0_rvalid", a_m0_rvalid, 0);

        // lock by port 1 across read then write while port 0 waits
        m0_req = 1; m0_addr = 32'h10;
        #1;
        check("lk_pre_m0_ready", a_m0_ready, 1);
        tick();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h20;
        #1;
        check("lk_rd_m1_ready", a_m1_ready, 1);
        check("lk_rd_m0_ready", a_m0_ready, 0);
        tick();
        m1_we = 1; m1_lock = 0; m1_wdata = 32'h12345678;
        #1;
        check("lk_wr_m1_ready", a_m1_ready, 1);
        check("lk_wr_m0_ready", a_m0_ready, 0);
        check("lk_wr_ram_addr", a_addr, 32'h20);
        check("lk_m1_rvalid", a_m1_rvalid, 1);
        tick();
        m1_req = 0; m1_we = 0;
        #1;
        check("lk_after_m0_ready", a_m0_ready, 1);
        tick();
        drop();

        // port 0 lock held over an idle gap
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        #1;
        check("gap_lock_m0_ready", a_m0_ready, 1);
        tick();
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gap_m1_ready", a_m1_ready, 0);
            check("gap_ram_wr", a_wr, 0);
            tick();
        end
        m0_lock = 0;
        #1;
        check("gap_release_m1_ready", a_m1_ready, 0);
        tick();
        #1;
        check("gap_grant_m1_ready", a_m1_ready, 1);
        check("gap_grant_ram_wr", a_wr, 1);
        tick();
        drop();

        // reset one cycle after a port 1 read on the latency-3 instance
        m1_req = 1; m1_addr = 32'h14;
        #1;
        check("rm_b_m1_ready", b_m1_ready, 1);
        tick();
        drop();
        reset = 1;
        #1;
        check("rm_b_m1_rvalid_rst", b_m1_rvalid, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rm_b_m1_rvalid", b_m1_rvalid, 0);
            tick();
        end
        m0_req = 1; m1_req = 1;
        #1;
        check("rm_tie_b_m0_ready", b_m0_ready, 1);
        check("rm_tie_b_m1_ready", b_m1_ready, 0);
        tick();
        drop();

        // port 1 write in the same cycle port 0's read returns
        m0_req = 1; m0_addr = 32'h10;
        #1;
        check("sw_m0_ready", a_m0_ready, 1);
        tick();
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h28; m1_wdata = 32'hA5A5A5A5;
        #1;
        check("sw_m1_ready", a_m1_ready, 1);
        check("sw_ram_wr", a_wr, 1);
        check("sw_ram_addr", a_addr, 32'h28);
        check("sw_m0_rvalid", a_m0_rvalid, 1);
        check("sw_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        tick();
        drop();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters.
- Port 0 is the CPU load/store port; port 1 is the loader/debug port used to preload or inspect RAM while the core runs or stalls.
- Arbitrates one access per cycle and drives the RAM's wr_sig/wr_data/addr pins.
- Returns read data to the owning requester after the RAM read latency; a lock mechanism supports atomic multi-access sequences.

Parameters:
RD_LATENCY, 1, cycles from accepted read to RAM rd_data valid (legal 1..4)
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins when not locked out

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 access request
m0_we  in  1  port 0 write enable (1 = write, 0 = read)
m0_lock  in  1  port 0 requests to keep ownership after this access
m0_addr  in  32  port 0 byte address
m0_wdata  in  32  port 0 write data
m0_ready  out  1  port 0 access accepted this cycle (combinational)
m0_rvalid  out  1  port 0 read data valid pulse
m0_rdata  out  32  port 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata  same as port 0, for port 1
ram_wr_sig  out  1  RAM write strobe
ram_wr_data  out  32  RAM write data
ram_addr  out  32  RAM address
ram_rd_data  in  32  RAM read data

Behaviour:
- Access accepted when mX_req & mX_ready at a rising edge. At most one ready high per cycle.
- ram_* outputs are combinational from the winning port. With no winner: ram_wr_sig=0, ram_addr=0, ram_wr_data=0.
- Read returns: an accepted read pushes the owner id into a RD_LATENCY-deep tag pipeline. When the tag emerges, the owner's rvalid pulses for exactly 1 cycle and its rdata = ram_rd_data. rdata holds its last value otherwise.
- Writes produce no rvalid.
- FSM states:
  - IDLE: no lock held.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- IDLE arbitration:
  - Only one req high -> that port wins.
  - Both high, FIXED_PRIO=1 -> port 0 wins.
  - Both high, FIXED_PRIO=0 -> the port not granted last wins. last_grant updates on every accept.
- IDLE -> OWNx: when port x is accepted with mx_lock=1.
- OWNx:
  - Only port x may win; the other port's ready=0.
  - Accept with mx_lock=0 -> IDLE.
  - Cycle with mx_req=0 and mx_lock=0 -> IDLE, no access.
  - mx_req=0 with mx_lock=1 -> stay in OWNx, idle cycle.
- Back-to-back accepts every cycle are allowed. Reads and writes may interleave freely.
- A write in the same cycle as an emerging read tag is legal; the tag's data is still routed.
- Requesters must hold req/we/addr/wdata/lock stable until ready.
- Reset, taking effect at the clock edge:
  - State = IDLE.
  - last_grant = port 1, so port 0 wins the first tie.
  - Tag pipeline flushed: no rvalid is issued for reads accepted before reset.
  - m0_rdata = m1_rdata = 0.
  - While reset is high: both ready=0, all ram_* outputs 0, both rvalid=0.
- Address and data pass through unmodified. No alignment check; alignment is the requester's responsibility.

Test Plan:
- Solo read: write 0xDEADBEEF to 0x10 via port 0, then read 0x10 via port 0 -> m0_ready=1 on each; m0_rvalid pulses exactly RD_LATENCY cycles after the read accept with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Round-robin: both ports request reads continuously from cycle 0 after reset -> grants alternate 0,1,0,1; each rvalid appears on the matching port RD_LATENCY cycles after its own accept. With FIXED_PRIO=1 -> port 0 granted every cycle, m1_ready=0.
- Lock: port 1 reads 0x20 with m1_lock=1, then writes 0x20 with m1_lock=0, while m0_req is held high -> m0_ready=0 for both cycles; port 0 is accepted on the next cycle.
- Lock hold with idle gap: port 0 locks, then holds req=0 and lock=1 for 3 cycles while m1_req=1 -> m1_ready stays 0, ram_wr_sig=0. Port 0 then drops lock -> port 1 granted on the following cycle.
- Reset mid-read: RD_LATENCY=3, accept a port 1 read, assert reset 1 cycle later -> no m1_rvalid ever appears for that read; after release, the first tie goes to port 0.
- Simultaneous write and returning read: RD_LATENCY=1, port 0 read at cycle n and port 1 write at cycle n+1 -> at n+1, ram_wr_sig=1 with port 1's address, and m0_rvalid=1 with the correct data.
